// File: rtl/histo_pkg.sv
// histo_pkg: shared constants, FSM state type and the saturating increment
// used by the histogram builder and its bank RAMs.
//   PIX_W  pixel intensity width (bin address width)
//   BIN_W  bin counter width, also the total-pixel counter width
//   NBINS  number of bins, 2^PIX_W
package histo_pkg;

  localparam int PIX_W = 8;
  localparam int BIN_W = 20;
  localparam int NBINS = 1 << PIX_W;

  // Cumulative sum over a scan and the width used for the 4*cum vs k*total compare.
  localparam int CUM_W = BIN_W + 2;
  localparam int CMP_W = BIN_W + 4;

  // Phase counter must reach NBINS+1 (last SCAN cycle).
  localparam int CNT_W = PIX_W + 2;

  localparam logic [CNT_W-1:0] CNT_BANK_LAST  = CNT_W'(NBINS - 1);
  localparam logic [CNT_W-1:0] CNT_NBINS      = CNT_W'(NBINS);
  localparam logic [CNT_W-1:0] CNT_SCAN_LAST  = CNT_W'(NBINS + 1);
  localparam logic [CNT_W-1:0] CNT_DRAIN_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    SCAN  = 3'd3,
    SWAP  = 3'd4,
    CLEAR = 3'd5
  } histo_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] v);
    return (&v) ? v : v + {{(BIN_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/histo_bank_ram.sv
// histo_bank_ram: simple dual-port RAM holding one histogram bank.
//   clk_i    clock
//   rst_i    synchronous reset, clears only the read data register
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled on the clock edge
//   rdata_o  read data, one cycle after raddr_i
// A read and a write to the same address in one cycle returns the old
// contents; the caller forwards around that.
module histo_bank_ram
  import histo_pkg::*;
#(
  parameter int AW = PIX_W,
  parameter int DW = BIN_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (rst_i) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/histogram_builder.sv
// histogram_builder: double-buffered 256-bin intensity histogram with
// per-frame max and 25/50/75 % cumulative-percentile bins.
//   iClk, iRst        clock, synchronous active-high reset
//   iValid, iPixel    pixel strobe and intensity (accepted only in ACCUM)
//   iFrameEnd         one-cycle pulse closing a frame
//   iHistoAddr        display-side bin address
//   oHistoValue       display bank content at iHistoAddr, 1-cycle latency
//   oMaxValue         largest bin of the last completed frame
//   oThreshPoint25/50/75  first bin where cumulative count reaches k/4 of total
//   oFrameDone        one-cycle pulse when new stats and bank become visible
//   oBusy             high outside ACCUM
//   oOverrun          sticky: input seen while busy
//   oDbgState         current FSM state
// Handshake: there is no back-pressure. iValid/iFrameEnd are taken only in
// ACCUM; anything offered in another state is dropped and flagged in oOverrun.
module histogram_builder
  import histo_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iValid,
  input  logic [PIX_W-1:0]   iPixel,
  input  logic               iFrameEnd,
  input  logic [PIX_W-1:0]   iHistoAddr,
  output logic [BIN_W-1:0]   oHistoValue,
  output logic [BIN_W-1:0]   oMaxValue,
  output logic [PIX_W-1:0]   oThreshPoint25,
  output logic [PIX_W-1:0]   oThreshPoint50,
  output logic [PIX_W-1:0]   oThreshPoint75,
  output logic               oFrameDone,
  output logic               oBusy,
  output logic               oOverrun,
  output histo_state_e       oDbgState
);

  histo_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic w_q, w_d;

  // Read-modify-write pipeline: stage 1 holds the address whose read is in
  // flight, the wr_* registers remember the last write for forwarding.
  logic             p1_v_q, p1_v_d;
  logic [PIX_W-1:0] p1_addr_q, p1_addr_d;
  logic             wr_v_q, wr_v_d;
  logic [PIX_W-1:0] wr_addr_q, wr_addr_d;
  logic [BIN_W-1:0] wr_data_q, wr_data_d;
  logic [BIN_W-1:0] total_q, total_d;

  // Scan state.
  logic                       sv_q, sv_d;
  logic [PIX_W-1:0]           sbin_q, sbin_d;
  logic [CUM_W-1:0]           cum_q, cum_d;
  logic [BIN_W-1:0]           smax_q, smax_d;
  logic [2:0]                 found_q, found_d;
  logic [2:0][PIX_W-1:0]      t_q, t_d;

  // Output registers.
  logic [BIN_W-1:0]           max_q, max_d;
  logic [2:0][PIX_W-1:0]      thr_q, thr_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;
  logic                       disp_sel_q, disp_sel_d;

  // Bank ports.
  logic [1:0]                 bank_we;
  logic [1:0][PIX_W-1:0]      bank_waddr;
  logic [1:0][BIN_W-1:0]      bank_wdata;
  logic [1:0][PIX_W-1:0]      bank_raddr;
  logic [1:0][BIN_W-1:0]      bank_rdata;

  logic             accept;
  logic [BIN_W-1:0] acc_rdata;
  logic             fwd_hit;
  logic [BIN_W-1:0] old_cnt;
  logic [BIN_W-1:0] new_cnt;
  logic [CUM_W-1:0] scan_cum;
  logic [CMP_W-1:0] cum_x4;
  logic [CMP_W-1:0] total_ext;
  logic [2:0][CMP_W-1:0] need;
  logic             w_rd;
  logic [PIX_W-1:0] int_raddr;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    histo_bank_ram #(
      .AW(PIX_W),
      .DW(BIN_W)
    ) u_bank (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .we_i    (bank_we[g]),
      .waddr_i (bank_waddr[g]),
      .wdata_i (bank_wdata[g]),
      .raddr_i (bank_raddr[g]),
      .rdata_o (bank_rdata[g])
    );
  end

  // Datapath helpers shared by accumulate and scan.
  always_comb begin
    accept    = (state_q == ACCUM) && iValid;
    acc_rdata = w_q ? bank_rdata[1] : bank_rdata[0];
    // The RAM returns pre-write data when the previous cycle wrote the same
    // bin, so take the value we just wrote instead.
    fwd_hit   = wr_v_q && (wr_addr_q == p1_addr_q);
    old_cnt   = fwd_hit ? wr_data_q : acc_rdata;
    new_cnt   = sat_inc(old_cnt);
    scan_cum  = cum_q + {2'b00, acc_rdata};
    cum_x4    = {scan_cum, 2'b00};
    total_ext = {4'b0000, total_q};
    need[0]   = total_ext;
    need[1]   = total_ext << 1;
    need[2]   = total_ext + (total_ext << 1);
  end

  // Bank port steering. In SWAP the select flips one cycle early so a display
  // read issued in that cycle already lands on the new display bank.
  always_comb begin
    w_rd       = (state_q == SWAP) ? ~w_q : w_q;
    int_raddr  = (state_q == SCAN) ? cnt_q[PIX_W-1:0] : iPixel;
    bank_raddr[0] = w_rd ? iHistoAddr : int_raddr;
    bank_raddr[1] = w_rd ? int_raddr : iHistoAddr;
    disp_sel_d = ~w_rd;
    for (int i = 0; i < 2; i++) begin
      bank_we[i]    = 1'b0;
      bank_waddr[i] = p1_addr_q;
      bank_wdata[i] = new_cnt;
      if (state_q == INIT) begin
        bank_we[i]    = 1'b1;
        bank_waddr[i] = cnt_q[PIX_W-1:0];
        bank_wdata[i] = '0;
      end else if (w_q == 1'(i)) begin
        if (state_q == CLEAR) begin
          bank_we[i]    = 1'b1;
          bank_waddr[i] = cnt_q[PIX_W-1:0];
          bank_wdata[i] = '0;
        end else begin
          bank_we[i]    = p1_v_q;
        end
      end
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    p1_v_d    = accept;
    p1_addr_d = iPixel;
    wr_v_d    = p1_v_q;
    wr_addr_d = p1_addr_q;
    wr_data_d = new_cnt;
    total_d   = accept ? sat_inc(total_q) : total_q;
    sv_d      = (state_q == SCAN) && (cnt_q < CNT_NBINS);
    sbin_d    = cnt_q[PIX_W-1:0];
    cum_d     = cum_q;
    smax_d    = smax_q;
    found_d   = found_q;
    t_d       = t_q;
    max_d     = max_q;
    thr_d     = thr_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q | ((iValid | iFrameEnd) && (state_q != ACCUM));

    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_BANK_LAST) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (iFrameEnd) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_DRAIN_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_SCAN_LAST) begin
          state_d = SWAP;
          cnt_d   = '0;
        end
      end
      SWAP: begin
        state_d = CLEAR;
        cnt_d   = '0;
        w_d     = ~w_q;
        max_d   = smax_q;
        thr_d   = t_q;
        done_d  = 1'b1;
        total_d = '0;
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_BANK_LAST) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    // Scan results restart during DRAIN; each bin arrives one cycle after
    // its address was issued. With total==0 every threshold hits bin 0.
    if (state_q == DRAIN) begin
      cum_d   = '0;
      smax_d  = '0;
      found_d = '0;
      t_d     = '0;
    end else if (sv_q) begin
      cum_d = scan_cum;
      if (acc_rdata > smax_q) begin
        smax_d = acc_rdata;
      end
      for (int k = 0; k < 3; k++) begin
        if (!found_q[k] && (cum_x4 >= need[k])) begin
          found_d[k] = 1'b1;
          t_d[k]     = sbin_q;
        end
      end
    end

    busy_d = (state_d != ACCUM);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      w_q        <= 1'b0;
      p1_v_q     <= 1'b0;
      p1_addr_q  <= '0;
      wr_v_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      total_q    <= '0;
      sv_q       <= 1'b0;
      sbin_q     <= '0;
      cum_q      <= '0;
      smax_q     <= '0;
      found_q    <= '0;
      t_q        <= '0;
      max_q      <= '0;
      thr_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      disp_sel_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_q        <= w_d;
      p1_v_q     <= p1_v_d;
      p1_addr_q  <= p1_addr_d;
      wr_v_q     <= wr_v_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      total_q    <= total_d;
      sv_q       <= sv_d;
      sbin_q     <= sbin_d;
      cum_q      <= cum_d;
      smax_q     <= smax_d;
      found_q    <= found_d;
      t_q        <= t_d;
      max_q      <= max_d;
      thr_q      <= thr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  assign oHistoValue    = disp_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign oMaxValue      = max_q;
  assign oThreshPoint25 = thr_q[0];
  assign oThreshPoint50 = thr_q[1];
  assign oThreshPoint75 = thr_q[2];
  assign oFrameDone     = done_q;
  assign oBusy          = busy_q;
  assign oOverrun       = ovr_q;
  assign oDbgState      = state_q;

endmodule

// File: tb/tb_histogram_builder.sv
module tb_histogram_builder;
  import histo_pkg::*;

  localparam int EW = BIN_W + 3 * PIX_W;
  localparam int RW = PIX_W + BIN_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               iRst = 1'b1;
  logic               iValid = 1'b0;
  logic [PIX_W-1:0]   iPixel = '0;
  logic               iFrameEnd = 1'b0;
  logic [PIX_W-1:0]   iHistoAddr = '0;
  logic [BIN_W-1:0]   oHistoValue;
  logic [BIN_W-1:0]   oMaxValue;
  logic [PIX_W-1:0]   oThreshPoint25;
  logic [PIX_W-1:0]   oThreshPoint50;
  logic [PIX_W-1:0]   oThreshPoint75;
  logic               oFrameDone;
  logic               oBusy;
  logic               oOverrun;
  histo_state_e       oDbgState;

  histogram_builder dut (
    .iClk           (clk),
    .iRst           (iRst),
    .iValid         (iValid),
    .iPixel         (iPixel),
    .iFrameEnd      (iFrameEnd),
    .iHistoAddr     (iHistoAddr),
    .oHistoValue    (oHistoValue),
    .oMaxValue      (oMaxValue),
    .oThreshPoint25 (oThreshPoint25),
    .oThreshPoint50 (oThreshPoint50),
    .oThreshPoint75 (oThreshPoint75),
    .oFrameDone     (oFrameDone),
    .oBusy          (oBusy),
    .oOverrun       (oOverrun),
    .oDbgState      (oDbgState)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];   // {max, t25, t50, t75} per completed frame
  logic [RW-1:0] rd_q[$];    // {addr, value} per display read
  int model_hist[NBINS];
  int frame_hist[NBINS];
  int pix_q[$];
  logic rd_issue = 1'b0;
  logic rd_pend = 1'b0;
  logic done_prev = 1'b0;
  logic [EW-1:0] mon_e;
  logic [RW-1:0] mon_r;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: stats straight from the definition of max and
  // "first bin whose cumulative count reaches k quarters of the total".
  function automatic logic [EW-1:0] ref_stats();
    longint total = 0;
    longint mx = 0;
    longint cum;
    longint sat = (longint'(1) << BIN_W) - 1;
    logic [PIX_W-1:0] t [3];
    for (int b = 0; b < NBINS; b++) begin
      total += model_hist[b];
      if (model_hist[b] > mx) mx = model_hist[b];
    end
    if (total > sat) total = sat;
    if (mx > sat) mx = sat;
    for (int k = 1; k <= 3; k++) begin
      cum = 0;
      t[k-1] = '0;
      for (int b = 0; b < NBINS; b++) begin
        cum += model_hist[b];
        if (4 * cum >= k * total) begin
          t[k-1] = PIX_W'(b);
          break;
        end
      end
    end
    return {BIN_W'(mx), t[0], t[1], t[2]};
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        check("bin_read_unexpected", 1, 0);
      end else begin
        mon_r = rd_q.pop_front();
        check($sformatf("bin_value[%0d]", mon_r[RW-1 -: PIX_W]), oHistoValue, mon_r[BIN_W-1:0]);
      end
    end
    if (done_prev) check("frame_done_pulse_width", oFrameDone, 0);
    if (oFrameDone && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("frame_done_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("max_value", oMaxValue, mon_e[EW-1 -: BIN_W]);
        check("thresh25", oThreshPoint25, mon_e[3*PIX_W-1 -: PIX_W]);
        check("thresh50", oThreshPoint50, mon_e[2*PIX_W-1 -: PIX_W]);
        check("thresh75", oThreshPoint75, mon_e[PIX_W-1:0]);
      end
    end
    done_prev <= oFrameDone;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iValid = 1'b0;
      iFrameEnd = 1'b0;
    end
  endtask

  task automatic send_frame(input bit fe_with_last, input int max_gap, input bit push);
    int n = pix_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iValid = 1'b1;
      iPixel = PIX_W'(pix_q[i]);
      iFrameEnd = fe_with_last && (i == n - 1);
      model_hist[pix_q[i]]++;
      if (i != n - 1) idle($urandom_range(0, max_gap));
    end
    if (!fe_with_last || n == 0) begin
      @(negedge clk);
      iValid = 1'b0;
      iFrameEnd = 1'b1;
    end
    if (push) exp_q.push_back(ref_stats());
    foreach (model_hist[b]) begin
      frame_hist[b] = push ? model_hist[b] : 0;
      model_hist[b] = 0;
    end
    @(negedge clk);
    iValid = 1'b0;
    iFrameEnd = 1'b0;
    pix_q.delete();
  endtask

  task automatic read_bins();
    for (int a = 0; a < NBINS; a++) begin
      iHistoAddr = PIX_W'(a);
      rd_issue = 1'b1;
      rd_q.push_back({PIX_W'(a), BIN_W'(frame_hist[a])});
      @(negedge clk);
    end
    rd_issue = 1'b0;
  endtask

  task automatic wait_frame_done();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (oFrameDone) break;
    end
    check("frame_done_timeout", i < 3000, 1);
    read_bins();
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (!oBusy) break;
      @(negedge clk);
    end
    check("busy_timeout", i < 3000, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_max", oMaxValue, 0);
    check("rst_t25", oThreshPoint25, 0);
    check("rst_t50", oThreshPoint50, 0);
    check("rst_t75", oThreshPoint75, 0);
    check("rst_frame_done", oFrameDone, 0);
    check("rst_busy", oBusy, 0);
    check("rst_overrun", oOverrun, 0);
    check("rst_histo_value", oHistoValue, 0);
  endtask

  // Release reset and check INIT lasts exactly NBINS cycles, then verify
  // the display bank reads all zero.
  task automatic release_and_init();
    iRst = 1'b0;
    repeat (NBINS - 1) @(negedge clk);
    check("init_busy_high", oBusy, 1);
    @(negedge clk);
    check("init_busy_low", oBusy, 0);
    foreach (frame_hist[b]) frame_hist[b] = 0;
    read_bins();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (model_hist[b]) model_hist[b] = 0;
    foreach (frame_hist[b]) frame_hist[b] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    release_and_init();

    // 100 identical pixels back-to-back, frame end on the last pixel.
    for (int i = 0; i < 100; i++) pix_q.push_back(7);
    send_frame(1'b1, 0, 1'b1);
    wait_frame_done();
    wait_idle();

    // 3,3,5,3 pattern exercises forwarding with interleaved bins.
    for (int i = 0; i < 100; i++) begin
      pix_q.push_back(3); pix_q.push_back(3); pix_q.push_back(5); pix_q.push_back(3);
    end
    send_frame(1'b0, 0, 1'b1);
    wait_frame_done();
    wait_idle();

    // Uniform ramp 0..255 four times.
    for (int r = 0; r < 4; r++) for (int v = 0; v < NBINS; v++) pix_q.push_back(v);
    send_frame(1'b1, 0, 1'b1);
    wait_frame_done();
    wait_idle();

    // Empty frame.
    send_frame(1'b0, 0, 1'b1);
    wait_frame_done();
    wait_idle();

    // Random frames with random gaps, biased toward a few bins for repeats.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 300; i++)
        pix_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(40, 47));
      send_frame(1'($urandom_range(0, 1)), 2, 1'b1);
      wait_frame_done();
      wait_idle();
    end
    check("no_overrun_yet", oOverrun, 0);

    // Pixels driven during SCAN are dropped and flag overrun.
    for (int i = 0; i < 50; i++) pix_q.push_back($urandom_range(0, 199));
    send_frame(1'b1, 1, 1'b1);
    idle(20);
    check("state_scan_for_drop", (oDbgState == SCAN), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iValid = 1'b1;
      iPixel = 8'd200;
    end
    idle(1);
    check("overrun_set", oOverrun, 1);
    wait_frame_done();
    wait_idle();
    for (int i = 0; i < 40; i++) pix_q.push_back($urandom_range(0, 199));
    send_frame(1'b0, 0, 1'b1);
    wait_frame_done();
    wait_idle();
    check("overrun_sticky", oOverrun, 1);

    // Reset in the middle of SCAN aborts the frame and clears everything.
    for (int i = 0; i < 30; i++) pix_q.push_back($urandom_range(0, 255));
    send_frame(1'b1, 0, 1'b0);
    idle(50);
    check("state_scan_for_reset", (oDbgState == SCAN), 1);
    iRst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    release_and_init();
    for (int i = 0; i < 20; i++) pix_q.push_back($urandom_range(100, 110));
    send_frame(1'b1, 0, 1'b1);
    wait_frame_done();
    wait_idle();

    idle(5);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/histogram_builder.md
Name: histogram_builder

Overview:
- Upstream neighbour of the histogram display stage. Builds a 256-bin intensity histogram from the camera pixel stream, one frame at a time.
- At each frame end it scans the finished histogram to produce the max bin value and the 25/50/75 % cumulative-percentile bins, then makes that histogram readable.
- Double-buffered. The display side reads the last completed frame while the current frame accumulates.

Parameters:
- PIX_W, 8, pixel intensity width; bin count NBINS = 2^PIX_W.
- BIN_W, 20, bin counter width; also the width of the total-pixel counter.

Ports:
- iClk  in  1  sole clock.
- iRst  in  1  synchronous, active-high reset.
- iValid  in  1  pixel strobe.
- iPixel  in  PIX_W  pixel intensity.
- iFrameEnd  in  1  single-cycle pulse after the last pixel of a frame; may coincide with the last iValid.
- iHistoAddr  in  PIX_W  display-side bin address.
- oHistoValue  out  BIN_W  display bank content at iHistoAddr; registered, 1-cycle latency.
- oMaxValue  out  BIN_W  largest bin of the last completed frame.
- oThreshPoint25  out  PIX_W  first bin where cumulative count reaches 25 % of the frame total.
- oThreshPoint50  out  PIX_W  same, 50 %.
- oThreshPoint75  out  PIX_W  same, 75 %.
- oFrameDone  out  1  one-cycle pulse when new stats and the new bank become visible.
- oBusy  out  1  high in any state other than ACCUM.
- oOverrun  out  1  sticky; set when iValid or iFrameEnd arrives while oBusy; cleared only by iRst.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst is synchronous and active-high.
- Reset values: all outputs 0. State INIT; bank select W=0.
- Banks: two NBINS x BIN_W RAMs, each with one synchronous read port and one write port. Accumulate bank is W; display bank is !W.
- INIT (NBINS cycles): clear both banks in parallel, address 0..NBINS-1, then go to ACCUM. A reset mid-operation re-enters INIT from any state.
- ACCUM: read-modify-write pipeline, one pixel per cycle.
  - Cycle t: read W[iPixel].
  - Cycle t+1: write W[addr] = old+1, saturating at 2^BIN_W-1.
  - Forwarding: if the addr at t+1 equals the address written the previous cycle, use the written value instead of RAM dout. Back-to-back identical pixels must count exactly.
  - Total-pixel counter increments per accepted pixel and saturates.
- iFrameEnd in ACCUM: an iValid on the same cycle is counted. Wait 2 cycles for the pipeline to drain, then go to SCAN.
- SCAN (NBINS+2 cycles): read W bins 0..NBINS-1 in order.
  - Accumulate cum (BIN_W+2 bits) and the running max.
  - Tk latches the first bin b where 4*cum(b) >= k*total, for k=1,2,3 (cum includes bin b).
  - If total==0, all thresholds and max are 0.
  - A threshold landing on bin 0 reports 0; the display stage treats that as disabled. Accepted.
- SWAP (1 cycle): W <= !W. Load oMaxValue and oThreshPoint* from scan results, pulse oFrameDone, clear the total counter.
- CLEAR (NBINS cycles): zero the new W bank, then go to ACCUM.
- Outputs hold their values between frames.
- Dead time: per-frame dead time is 2NBINS+5 cycles. Input arriving in that window is dropped and sets oOverrun.
- Display port: always reads !W and is unaffected by state. Across SWAP, a read issued in the SWAP cycle returns the new bank.

Decomposition:
- Package histo_pkg: PIX_W, BIN_W, NBINS, state enum {INIT, ACCUM, DRAIN, SCAN, SWAP, CLEAR}, and the saturating-increment function.
- One sub-module, histo_bank_ram: simple dual-port RAM, synchronous read, write-first not required. Instantiate it twice.

Test Plan:
- Reset, wait INIT. Feed 100 pixels of value 7 back-to-back, then iFrameEnd. Required: bank bin7=100 and all others 0; oMaxValue=100; T25=T50=T75=7; one oFrameDone.
- Alternating 3,3,5,3 streams of 400 pixels (300 threes, 100 fives). Required: forwarding correct, bin3=300, bin5=100; T25=3, T50=3, T75=3; max=300.
- Uniform ramp 0..255 repeated 4 times (1024 px). Required: max=4; T25=63, T50=127, T75=191.
- Empty frame (iFrameEnd with no pixels). Required: max=0, thresholds 0, oFrameDone pulses, bins read 0.
- Pixels driven during SCAN/CLEAR. Required: oOverrun=1 and sticky; dropped pixels absent from the next frame.
- iRst asserted mid-SCAN. Required: next cycle all outputs 0; after NBINS cycles oBusy=0; both banks read 0.
